axi4_lite_nm_arbiter: RTL and testbench
=======================================

AXI4_LITE_NM_ARBITER -- requirements
Module: axi4_lite_nm_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of master ports, legal 2..8.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width, multiple of 8; strobe width STRB_W=DATA_W/8.
REQ-004 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-006 SHALL have AW ports: m_awaddr in NUM_MASTERS*ADDR_W, m_awvalid in NUM_MASTERS, m_awready out NUM_MASTERS (master i in slice i).
REQ-007 SHALL have W ports: m_wdata in NUM_MASTERS*DATA_W, m_wstrb in NUM_MASTERS*STRB_W, m_wvalid in NUM_MASTERS, m_wready out NUM_MASTERS.
REQ-008 SHALL have B ports: m_bresp out NUM_MASTERS*2, m_bvalid out NUM_MASTERS, m_bready in NUM_MASTERS.
REQ-009 SHALL have AR ports: m_araddr in NUM_MASTERS*ADDR_W, m_arvalid in NUM_MASTERS, m_arready out NUM_MASTERS.
REQ-010 SHALL have R ports: m_rdata out NUM_MASTERS*DATA_W, m_rresp out NUM_MASTERS*2, m_rvalid out NUM_MASTERS, m_rready in NUM_MASTERS.
REQ-011 SHALL have slave ports s_aw*/s_w*/s_b*/s_ar*/s_r*, single-slot widths, directions mirrored from master side.
REQ-012 SHALL have grant_id, output, clog2(NUM_MASTERS), currently granted master; busy, output, 1, state!=IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, RD, WR; grant_id and state registered.
REQ-014 In IDLE, request_i = m_arvalid[i] | m_awvalid[i]; no master is connected to slave in IDLE (all s_*valid, m_*ready, m_*valid 0).
REQ-015 In IDLE with any request, SHALL latch winner into grant_id and move to RD if winner's arvalid=1, else WR; arbitration latency exactly 1 cycle.
REQ-016 Master asserting arvalid and awvalid together SHALL be served read first; its write re-arbitrates afterwards.
REQ-017 In RD, SHALL pass only AR and R channels of granted master to slave; AW/W/B of all masters blocked (ready/valid 0, bresp 0).
REQ-018 In WR, SHALL pass AW, W, B of granted master; AW and W may handshake in either order or same cycle; AR/R blocked.
REQ-019 RD SHALL return to IDLE on cycle after s_rvalid&s_rready; WR on cycle after s_bvalid&s_bready; no back-to-back grant without one IDLE cycle.
REQ-020 Non-granted master outputs SHALL be 0 (data, resp, valid, ready) every cycle.
REQ-021 Grant SHALL be stable for the whole transaction regardless of other requests or the granted master dropping valid.
REQ-022 Fixed-priority mode: lowest index requester wins.
REQ-023 Slave response codes SHALL pass through unmodified, including SLVERR/DECERR.

Reset
REQ-024 While rst_n=0: state=IDLE, grant_id=0, busy=0, all valid/ready outputs 0, all data/resp outputs 0; mid-transaction reset abandons transaction with no response.
REQ-025 Deassertion SHALL be synchronised by surrounding logic; first arbitration no earlier than first edge after release.

Configuration
REQ-026 Macro AXI_ARB_RR_EN defined: round-robin; winner is first requester at index > last granted (wrapping), pointer updated on grant, reset pointer = NUM_MASTERS-1 so master 0 wins first.
REQ-027 Macro AXI_ARB_RR_EN undefined: fixed priority per REQ-022, no pointer register.

Structure
REQ-028 AXI response codes (OKAY/EXOKAY/SLVERR/DECERR) and FSM state encoding SHALL live in shared package axi4_lite_pkg.
REQ-029 Winner selection SHALL be sub-module axi_arb_picker (request vector, last-grant pointer in; grant index, valid out), purely combinational.

Verification
REQ-030 Reset, no requests -> busy=0, grant_id=0, all s_*valid=0 for 20 cycles.
REQ-031 N=4, fixed priority, m_arvalid=4'b1010 same cycle -> master 1 served, then master 3; each R data 0xDEADBEEF routed only to its master.
REQ-032 N=4, AXI_ARB_RR_EN, all four arvalid held continuously -> grant order 0,1,2,3,0 with one IDLE cycle between.
REQ-033 Master 2 write, W handshake before AW, slave bresp=2'b10 -> m_bresp[2]=2'b10, state WR->IDLE after B handshake.
REQ-034 Master 0 arvalid+awvalid together -> read completes first, then write granted; meanwhile master 1 sees all ready=0.
REQ-035 rst_n low during RD with s_rvalid pending -> all outputs 0 asynchronously, IDLE after release, next request arbitrates normally.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and arbiter FSM encoding.
// No logic; types and constants only.
// Backpressure: n/a.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_arb_picker.sv
// Winner select: first requester above the last-grant index, wrapping to the lowest.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the pick.
module axi_arb_picker
    import axi4_lite_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant_idx,
    output logic          grant_vld
);

    // The upper pass overrides the wrapped pass, and within each pass the
    // lowest index is written last, so it wins.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (IW'(i) <= last)) begin
                grant_idx = IW'(i);
                grant_vld = 1'b1;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (IW'(i) > last)) begin
                grant_idx = IW'(i);
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_lite_nm_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter; AXI_ARB_RR_EN selects round-robin, else fixed priority.
// Latency: 1 cycle arbitration in IDLE, then transparent combinational path for the granted master.
// Backpressure: slave ready/valid passed straight through; one IDLE cycle between grants.
module axi4_lite_nm_arbiter
    import axi4_lite_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    localparam int STRB_W     = DATA_W / 8,
    localparam int IW         = idx_w(NUM_MASTERS)
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr,
    input  logic [NUM_MASTERS-1:0]        m_awvalid,
    output logic [NUM_MASTERS-1:0]        m_awready,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS*STRB_W-1:0] m_wstrb,
    input  logic [NUM_MASTERS-1:0]        m_wvalid,
    output logic [NUM_MASTERS-1:0]        m_wready,
    output logic [NUM_MASTERS*2-1:0]      m_bresp,
    output logic [NUM_MASTERS-1:0]        m_bvalid,
    input  logic [NUM_MASTERS-1:0]        m_bready,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
    input  logic [NUM_MASTERS-1:0]        m_arvalid,
    output logic [NUM_MASTERS-1:0]        m_arready,
    output logic [NUM_MASTERS*DATA_W-1:0] m_rdata,
    output logic [NUM_MASTERS*2-1:0]      m_rresp,
    output logic [NUM_MASTERS-1:0]        m_rvalid,
    input  logic [NUM_MASTERS-1:0]        m_rready,

    output logic [ADDR_W-1:0]             s_awaddr,
    output logic                          s_awvalid,
    input  logic                          s_awready,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [STRB_W-1:0]             s_wstrb,
    output logic                          s_wvalid,
    input  logic                          s_wready,
    input  logic [1:0]                    s_bresp,
    input  logic                          s_bvalid,
    output logic                          s_bready,
    output logic [ADDR_W-1:0]             s_araddr,
    output logic                          s_arvalid,
    input  logic                          s_arready,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic [1:0]                    s_rresp,
    input  logic                          s_rvalid,
    output logic                          s_rready,

    output logic [IW-1:0]                 grant_id,
    output logic                          busy
);

    arb_state_t    state, next_state;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic [IW-1:0] last_grant;
    logic          win_ar;
    logic          ar_done, aw_done, w_done;

    axi_arb_picker #(.N(NUM_MASTERS), .IW(IW)) u_picker (
        .req       (m_arvalid | m_awvalid),
        .last      (last_grant),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

`ifdef AXI_ARB_RR_EN
    logic [IW-1:0] rr_ptr;

    // Reset value makes master 0 the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= IW'(NUM_MASTERS - 1);
        end else if (state == ST_IDLE && pick_vld) begin
            rr_ptr <= pick_idx;
        end
    end

    assign last_grant = rr_ptr;
`else
    assign last_grant = IW'(NUM_MASTERS - 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant_id <= '0;
            ar_done  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE) begin
                ar_done <= 1'b0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (pick_vld) begin
                    grant_id <= pick_idx;
                end
            end else begin
                if (s_arvalid && s_arready) ar_done <= 1'b1;
                if (s_awvalid && s_awready) aw_done <= 1'b1;
                if (s_wvalid  && s_wready)  w_done  <= 1'b1;
            end
        end
    end

    // A winner with both AR and AW pending is served read first.
    always_comb begin
        next_state = state;
        win_ar     = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick_idx == IW'(i)) win_ar = m_arvalid[i];
        end
        case (state)
            ST_IDLE: if (pick_vld) next_state = win_ar ? ST_RD : ST_WR;
            ST_RD:   if (s_rvalid && s_rready) next_state = ST_IDLE;
            ST_WR:   if (s_bvalid && s_bready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_awready = '0;
        m_wready  = '0;
        m_bresp   = '0;
        m_bvalid  = '0;
        m_arready = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        m_rvalid  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_id == IW'(i)) begin
                if (state == ST_RD) begin
                    s_araddr                    = m_araddr[i*ADDR_W +: ADDR_W];
                    s_arvalid                   = m_arvalid[i] & ~ar_done;
                    m_arready[i]                = s_arready & ~ar_done;
                    m_rdata[i*DATA_W +: DATA_W] = s_rdata;
                    m_rresp[i*2 +: 2]           = s_rresp;
                    m_rvalid[i]                 = s_rvalid;
                    s_rready                    = m_rready[i];
                end else if (state == ST_WR) begin
                    s_awaddr          = m_awaddr[i*ADDR_W +: ADDR_W];
                    s_awvalid         = m_awvalid[i] & ~aw_done;
                    m_awready[i]      = s_awready & ~aw_done;
                    s_wdata           = m_wdata[i*DATA_W +: DATA_W];
                    s_wstrb           = m_wstrb[i*STRB_W +: STRB_W];
                    s_wvalid          = m_wvalid[i] & ~w_done;
                    m_wready[i]       = s_wready & ~w_done;
                    m_bresp[i*2 +: 2] = s_bresp;
                    m_bvalid[i]       = s_bvalid;
                    s_bready          = m_bready[i];
                end
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_axi4_lite_nm_arbiter.sv
// Scoreboard bench for the 4-master arbiter: grant order, routed R/B data, isolation, reset.
// Slave model reacts one cycle after each handshake; expectations are queued by the stimulus.
// Backpressure: slave AW can be held until W has been accepted.
module tb_axi4_lite_nm_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clk;
    logic            rst_n;
    logic [N*AW-1:0] m_awaddr, m_araddr;
    logic [N-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
    logic [N*DW-1:0] m_wdata, m_rdata;
    logic [N*SW-1:0] m_wstrb;
    logic [N*2-1:0]  m_bresp, m_rresp;
    logic [AW-1:0]   s_awaddr, s_araddr;
    logic [DW-1:0]   s_wdata, s_rdata;
    logic [SW-1:0]   s_wstrb;
    logic [1:0]      s_bresp, s_rresp;
    logic            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic            s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]      grant_id;
    logic            busy;

    axi4_lite_nm_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant_id(grant_id), .busy(busy)
    );

    typedef struct { int m; logic [31:0] data; logic [1:0] resp; } rexp_t;
    typedef struct { int m; logic [1:0] resp; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } bexp_t;
    typedef struct { int id; int gap; } gexp_t;

    rexp_t rq[$];
    bexp_t bq[$];
    gexp_t gq[$];

    int total = 0;
    int bad   = 0;

    logic        slv_wfirst;
    logic [1:0]  slv_bresp;
    logic        aw_seen, w_seen;
    logic [31:0] cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_grant"}, grant_id, 0);
        chk({name, "_slave"}, |{s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
                                s_araddr, s_arvalid, s_rready}, 0);
        chk({name, "_master"}, |{m_awready, m_wready, m_bresp, m_bvalid, m_arready,
                                 m_rdata, m_rresp, m_rvalid}, 0);
    endtask

    // Slave model: R data is DEADBEEF ^ address, R resp is address bits [3:2].
    initial begin
        logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
        logic [31:0] ar_a, aw_a, wd;
        logic [3:0]  ws;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
        aw_seen = 0; w_seen = 0; cap_awaddr = 0; cap_wdata = 0; cap_wstrb = 0;
        forever begin
            @(negedge clk);
            ar_hs = s_arvalid && s_arready;
            r_hs  = s_rvalid && s_rready;
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            b_hs  = s_bvalid && s_bready;
            ar_a = s_araddr; aw_a = s_awaddr; wd = s_wdata; ws = s_wstrb;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
                s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
                aw_seen = 0; w_seen = 0;
            end else begin
                if (r_hs) begin s_rvalid = 0; s_rdata = 0; s_rresp = 0; end
                if (ar_hs) begin
                    s_rvalid = 1; s_rdata = 32'hDEADBEEF ^ ar_a; s_rresp = ar_a[3:2];
                end
                if (aw_hs) begin aw_seen = 1; cap_awaddr = aw_a; end
                if (w_hs)  begin w_seen = 1; cap_wdata = wd; cap_wstrb = ws; end
                if (b_hs) begin
                    s_bvalid = 0; s_bresp = 0; aw_seen = 0; w_seen = 0;
                end else if (aw_seen && w_seen && !s_bvalid) begin
                    s_bvalid = 1; s_bresp = slv_bresp;
                end
                s_arready = 1;
                s_wready  = !w_seen;
                s_awready = slv_wfirst ? (w_seen && !aw_seen) : !aw_seen;
            end
        end
    end

    // Monitor: grant order and idle gap, routed responses, isolation of other masters.
    initial begin
        logic  busy_prev, done_prev, leak, rb;
        int    idle_cnt;
        gexp_t g;
        rexp_t r;
        bexp_t b;
        busy_prev = 0; done_prev = 0; idle_cnt = 99;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_prev = 0; done_prev = 0; idle_cnt = 99;
            end else begin
                if (busy) begin
                    if (!busy_prev) begin
                        chk("grant_expected", gq.size() > 0, 1);
                        if (gq.size() > 0) begin
                            g = gq.pop_front();
                            chk("grant_id", grant_id, g.id);
                            if (g.gap >= 0) chk("grant_gap", idle_cnt, g.gap);
                        end
                    end
                    idle_cnt = 0;
                end else begin
                    idle_cnt++;
                    chk("idle_slave", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 0);
                end
                busy_prev = busy;

                leak = 0;
                for (int i = 0; i < N; i++) begin
                    if (!(busy && grant_id == i)) begin
                        leak = leak | m_awready[i] | m_wready[i] | m_bvalid[i] | m_arready[i]
                             | m_rvalid[i] | (|m_bresp[i*2 +: 2]) | (|m_rresp[i*2 +: 2])
                             | (|m_rdata[i*DW +: DW]);
                    end
                end
                chk("isolation", leak, 0);

                if (done_prev) chk("idle_after_resp", busy, 0);
                rb = |(m_rvalid & m_rready) | |(m_bvalid & m_bready);
                done_prev = rb;

                for (int i = 0; i < N; i++) begin
                    if (m_rvalid[i] && m_rready[i]) begin
                        chk("r_expected", rq.size() > 0, 1);
                        if (rq.size() > 0) begin
                            r = rq.pop_front();
                            chk("r_master", i, r.m);
                            chk("r_data", m_rdata[i*DW +: DW], r.data);
                            chk("r_resp", m_rresp[i*2 +: 2], r.resp);
                        end
                    end
                    if (m_bvalid[i] && m_bready[i]) begin
                        chk("b_expected", bq.size() > 0, 1);
                        if (bq.size() > 0) begin
                            b = bq.pop_front();
                            chk("b_master", i, b.m);
                            chk("b_resp", m_bresp[i*2 +: 2], b.resp);
                            chk("aw_addr", cap_awaddr, b.addr);
                            chk("w_data", cap_wdata, b.data);
                            chk("w_strb", cap_wstrb, b.strb);
                        end
                    end
                end
            end
        end
    end

    task automatic mread(input int i, input logic [31:0] a);
        int n;
        logic hit;
        n = 0; hit = 0;
        @(posedge clk);
        #1;
        m_araddr[i*AW +: AW] = a;
        m_arvalid[i] = 1'b1;
        while (!hit && n < 200) begin
            @(negedge clk);
            n++;
            hit = m_arready[i];
        end
        chk("ar_handshake", hit, 1);
        @(posedge clk);
        #1;
        m_arvalid[i] = 1'b0;
        m_araddr[i*AW +: AW] = '0;
    endtask

    task automatic mwrite(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        logic aw_ok, w_ok, aw_hit, w_hit;
        n = 0; aw_ok = 0; w_ok = 0;
        @(posedge clk);
        #1;
        m_awaddr[i*AW +: AW] = a;
        m_wdata[i*DW +: DW]  = d;
        m_wstrb[i*SW +: SW]  = s;
        m_awvalid[i] = 1'b1;
        m_wvalid[i]  = 1'b1;
        while (!(aw_ok && w_ok) && n < 200) begin
            @(negedge clk);
            n++;
            aw_hit = !aw_ok && m_awready[i];
            w_hit  = !w_ok && m_wready[i];
            if (aw_hit || w_hit) begin
                @(posedge clk);
                #1;
                if (aw_hit) begin
                    aw_ok = 1; m_awvalid[i] = 1'b0; m_awaddr[i*AW +: AW] = '0;
                end
                if (w_hit) begin
                    w_ok = 1; m_wvalid[i] = 1'b0; m_wdata[i*DW +: DW] = '0; m_wstrb[i*SW +: SW] = '0;
                end
            end
        end
        chk("aw_handshake", aw_ok, 1);
        chk("w_handshake", w_ok, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || rq.size() > 0 || bq.size() > 0 || gq.size() > 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drained", rq.size() + bq.size() + gq.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0; m_wvalid = '0;
        m_araddr = '0; m_arvalid = '0;
        m_bready = '1; m_rready = '1;
        slv_wfirst = 0; slv_bresp = 2'b00;

        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("noreq_busy", busy, 0);
            chk("noreq_grant", grant_id, 0);
            chk("noreq_svalid", {s_arvalid, s_awvalid, s_wvalid}, 0);
        end

        // Masters 1 and 3 read together: lower index first, both get DEADBEEF.
        gq.push_back('{1, -1});
        gq.push_back('{3, 1});
        rq.push_back('{1, 32'hDEADBEEF, 2'b00});
        rq.push_back('{3, 32'hDEADBEEF, 2'b00});
        fork
            mread(1, 32'h0);
            mread(3, 32'h0);
        join
        wait_idle();

        // All four masters read; master 0 issues a second read straight away.
`ifdef AXI_ARB_RR_EN
        gq.push_back('{0, -1}); gq.push_back('{1, 1}); gq.push_back('{2, 1});
        gq.push_back('{3, 1});  gq.push_back('{0, 1});
        rq.push_back('{0, 32'hDEADBEEF ^ 32'h1000, 2'b00});
        rq.push_back('{1, 32'hDEADBEEF ^ 32'h2004, 2'b01});
        rq.push_back('{2, 32'hDEADBEEF ^ 32'h3008, 2'b10});
        rq.push_back('{3, 32'hDEADBEEF ^ 32'h400C, 2'b11});
        rq.push_back('{0, 32'hDEADBEEF ^ 32'h0010, 2'b00});
`else
        gq.push_back('{0, -1}); gq.push_back('{0, 1}); gq.push_back('{1, 1});
        gq.push_back('{2, 1});  gq.push_back('{3, 1});
        rq.push_back('{0, 32'hDEADBEEF ^ 32'h1000, 2'b00});
        rq.push_back('{0, 32'hDEADBEEF ^ 32'h0010, 2'b00});
        rq.push_back('{1, 32'hDEADBEEF ^ 32'h2004, 2'b01});
        rq.push_back('{2, 32'hDEADBEEF ^ 32'h3008, 2'b10});
        rq.push_back('{3, 32'hDEADBEEF ^ 32'h400C, 2'b11});
`endif
        fork
            begin mread(0, 32'h1000); mread(0, 32'h0010); end
            mread(1, 32'h2004);
            mread(2, 32'h3008);
            mread(3, 32'h400C);
        join
        wait_idle();

        // Master 2 write, slave takes W before AW and answers SLVERR.
        slv_wfirst = 1; slv_bresp = 2'b10;
        gq.push_back('{2, -1});
        bq.push_back('{2, 2'b10, 32'h0000_2220, 32'hCAFE_0002, 4'b0110});
        mwrite(2, 32'h0000_2220, 32'hCAFE_0002, 4'b0110);
        wait_idle();
        slv_wfirst = 0; slv_bresp = 2'b00;

        // Master 0 read+write together, master 1 read competing.
`ifdef AXI_ARB_RR_EN
        gq.push_back('{0, -1}); gq.push_back('{1, 1}); gq.push_back('{0, 1});
`else
        gq.push_back('{0, -1}); gq.push_back('{0, 1}); gq.push_back('{1, 1});
`endif
        rq.push_back('{0, 32'hDEADBEEF ^ 32'h5004, 2'b01});
        rq.push_back('{1, 32'hDEADBEEF ^ 32'h7008, 2'b10});
        bq.push_back('{0, 2'b00, 32'h0000_6000, 32'h1234_5678, 4'hF});
        fork
            mread(0, 32'h5004);
            mwrite(0, 32'h0000_6000, 32'h1234_5678, 4'hF);
            mread(1, 32'h7008);
        join
        wait_idle();

        // Reset while master 2's read data is stalled.
        m_rready[2] = 1'b0;
        gq.push_back('{2, -1});
        mread(2, 32'h800C);
        repeat (2) @(negedge clk);
        chk("rd_pending", {busy, s_rvalid}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("midreset");
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        m_rready[2] = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", busy, 0);
        gq.push_back('{3, -1});
        rq.push_back('{3, 32'hDEADBEEF ^ 32'h9000, 2'b00});
        mread(3, 32'h9000);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
